// File: rtl/debug_scan_capture.sv
// debug_scan_capture: walks all 32 debug addresses, settles, and captures Test_signal
// into a 32x32 snapshot buffer with an indexed combinational read port.
module debug_scan_capture #(
    parameter int SETTLE_CYCLES = 1,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   abort,
    input  logic [4:0]             live_sel,
    output logic [4:0]             Debug_addr,
    input  logic [31:0]            Test_signal,
    output logic                   busy,
    output logic                   done,
    output logic                   snap_valid,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    input  logic [4:0]             rd_idx,
    output logic [31:0]            rd_data
);
    typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
    state_t                 state, state_d;
    logic [4:0]             addr_q, addr_d;
    logic [3:0]             wait_cnt, wait_d;
    logic                   snap_d, wr;
    logic [FRAME_CNT_W-1:0] cnt_d;
    logic [31:0]            mem [32];
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign Debug_addr = state == IDLE ? live_sel : addr_q;
    assign rd_data    = mem[rd_idx];
    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        wait_d  = wait_cnt;
        snap_d  = snap_valid;
        cnt_d   = frame_cnt;
        wr      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_d = SAMPLE;
                addr_d  = '0;
                wait_d  = SETTLE;
                snap_d  = 1'b0;
            end
            SAMPLE: if (abort) begin
                state_d = IDLE;
                snap_d  = 1'b0;
            end else if (wait_cnt != '0) begin
                wait_d = wait_cnt - 4'd1;
            end else begin
                wr = 1'b1;
                if (addr_q == 5'd31) state_d = DONE;
                else begin
                    addr_d = addr_q + 5'd1;
                    wait_d = SETTLE;
                end
            end
            DONE: if (abort) begin
                state_d = IDLE;
                snap_d  = 1'b0;
            end else begin
                // count and validity commit on the DONE exit edge so a coincident abort can veto them
                cnt_d   = frame_cnt + FRAME_CNT_W'(1);
                snap_d  = 1'b1;
                state_d = continuous ? SAMPLE : IDLE;
                addr_d  = continuous ? 5'd0 : addr_q;
                wait_d  = continuous ? SETTLE : wait_cnt;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            addr_q     <= '0;
            wait_cnt   <= '0;
            snap_valid <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_d;
            addr_q     <= addr_d;
            wait_cnt   <= wait_d;
            snap_valid <= snap_d;
            frame_cnt  <= cnt_d;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[addr_q] <= Test_signal;
        end
    end
endmodule

// File: tb/tb_debug_scan_capture.sv
// tb_debug_scan_capture: scoreboard bench for two scan-capture instances
// (settle 1 / 16-bit count, and settle 2 / 2-bit count with a delayed test mux).
module tb_debug_scan_capture;
    logic        clk = 0, rstn = 0;
    logic        start_a = 0, cont_a = 0, abort_a = 0;
    logic        start_b = 0, cont_b = 0, abort_b = 0;
    logic [4:0]  live_sel = 5'd9, rd_idx = 5'd0;
    logic [4:0]  addr_a, addr_b, d1, d2;
    logic [31:0] ts_a, ts_b, rd_a, rd_b;
    logic        busy_a, done_a, snap_a, busy_b, done_b, snap_b;
    logic [15:0] fc_a;
    logic [1:0]  fc_b;
    logic [15:0] pat_a = 16'hA5A5;
    int          cyc = 0, vectors = 0, miscompares = 0, exp_fc_a = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // second test mux only reflects the address two cycles after it is driven
    always @(posedge clk) begin
        d1 <= addr_b;
        d2 <= d1;
    end
    assign ts_a = {pat_a, 11'h0, addr_a};
    assign ts_b = {16'hA5A5, 11'h0, d2};

    debug_scan_capture #(.SETTLE_CYCLES(1), .FRAME_CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .continuous(cont_a), .abort(abort_a),
        .live_sel(live_sel), .Debug_addr(addr_a), .Test_signal(ts_a), .busy(busy_a),
        .done(done_a), .snap_valid(snap_a), .frame_cnt(fc_a), .rd_idx(rd_idx), .rd_data(rd_a));

    debug_scan_capture #(.SETTLE_CYCLES(2), .FRAME_CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .continuous(cont_b), .abort(abort_b),
        .live_sel(live_sel), .Debug_addr(addr_b), .Test_signal(ts_b), .busy(busy_b),
        .done(done_b), .snap_valid(snap_b), .frame_cnt(fc_b), .rd_idx(rd_idx), .rd_data(rd_b));

    task automatic push_frame(input logic [15:0] p, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) exp_q.push_back({p, 11'h0, 5'(k)});
    endtask

    task automatic read_all(input bit b, input string tag);
        logic [31:0] e, g;
        for (int k = 0; k < 32; k++) begin
            rd_idx = 5'(k);
            #1;
            g = b ? rd_b : rd_a;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s[%0d]: got %h, scoreboard empty", tag, k, g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: got %h want %h", tag, k, g, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic launch(input bit b, input bit hold, output int t0);
        if (b) start_b = 1; else start_a = 1;
        @(negedge clk);
        t0 = cyc;
        if (!hold) begin
            start_a = 0;
            start_b = 0;
        end
    endtask

    task automatic wait_done(input bit b, input int lim, output int t, output bit dropped);
        int n = 0;
        dropped = 0;
        while ((b ? done_b : done_a) !== 1'b1 && n < lim) begin
            if ((b ? busy_b : busy_a) !== 1'b1) dropped = 1;
            @(negedge clk);
            n++;
        end
        t = cyc;
        vectors++;
        if (n >= lim) begin
            miscompares++;
            $display("FAIL wait_done: got no done, want done within %0d cycles", lim);
        end
    endtask

    task automatic test_reset;
        #12;
        vectors++; if (addr_a !== 5'd9) begin miscompares++; $display("FAIL rst_addr: got %0d want 9", addr_a); end
        vectors++; if ({busy_a, done_a, snap_a} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {busy_a, done_a, snap_a}); end
        vectors++; if (fc_a !== 16'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d want 0", fc_a); end
        vectors++; if (rd_a !== 32'd0 || rd_b !== 32'd0) begin miscompares++; $display("FAIL rst_buf: got %h/%h want 0", rd_a, rd_b); end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        int t0, t;
        bit dr;
        push_frame(16'hA5A5, 0, 31);
        launch(0, 0, t0);
        wait_done(0, 200, t, dr);
        vectors++; if (t - t0 !== 64) begin miscompares++; $display("FAIL single_latency: got %0d want 64", t - t0); end
        @(negedge clk);
        exp_fc_a++;
        vectors++; if (fc_a !== 16'(exp_fc_a)) begin miscompares++; $display("FAIL single_cnt: got %0d want %0d", fc_a, exp_fc_a); end
        vectors++; if ({snap_a, busy_a, done_a} !== 3'b100) begin miscompares++; $display("FAIL single_flags: got %b want 100", {snap_a, busy_a, done_a}); end
        read_all(0, "single");
    endtask

    task automatic test_settle;
        int t0, t;
        bit dr;
        push_frame(16'hA5A5, 0, 31);
        launch(1, 0, t0);
        wait_done(1, 300, t, dr);
        vectors++; if (t - t0 !== 96) begin miscompares++; $display("FAIL settle_latency: got %0d want 96", t - t0); end
        @(negedge clk);
        vectors++; if ({snap_b, fc_b} !== 3'b101) begin miscompares++; $display("FAIL settle_state: got %b want 101", {snap_b, fc_b}); end
        read_all(1, "settle");
    endtask

    task automatic test_continuous;
        int t0, t;
        bit dr, any_drop = 0;
        int exp_t [4] = '{64, 129, 194, 259};
        push_frame(16'hA5A5, 0, 31);
        cont_a = 1;
        launch(0, 0, t0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cont_a = 0;
            wait_done(0, 200, t, dr);
            any_drop |= dr;
            vectors++; if (t - t0 !== exp_t[i]) begin miscompares++; $display("FAIL cont_done%0d: got %0d want %0d", i, t - t0, exp_t[i]); end
            @(negedge clk);
        end
        exp_fc_a += 4;
        vectors++; if (any_drop !== 1'b0) begin miscompares++; $display("FAIL cont_busy: got drop=1 want 0"); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL cont_stop: got busy=%b want 0", busy_a); end
        vectors++; if (fc_a !== 16'(exp_fc_a)) begin miscompares++; $display("FAIL cont_cnt: got %0d want %0d", fc_a, exp_fc_a); end
        read_all(0, "cont");
    endtask

    task automatic test_abort;
        int t0;
        bit extra = 0;
        pat_a = 16'h5A5A;
        push_frame(16'h5A5A, 0, 13);
        push_frame(16'hA5A5, 14, 31);
        launch(0, 0, t0);
        while (cyc < t0 + 29) @(negedge clk);
        abort_a = 1;
        @(negedge clk);
        abort_a = 0;
        vectors++; if ({busy_a, snap_a, done_a} !== 3'b000) begin miscompares++; $display("FAIL abort_flags: got %b want 000", {busy_a, snap_a, done_a}); end
        vectors++; if (fc_a !== 16'(exp_fc_a)) begin miscompares++; $display("FAIL abort_cnt: got %0d want %0d", fc_a, exp_fc_a); end
        vectors++; if (addr_a !== 5'd9) begin miscompares++; $display("FAIL abort_addr: got %0d want 9", addr_a); end
        for (int i = 0; i < 70; i++) begin
            if (done_a !== 1'b0) extra = 1;
            @(negedge clk);
        end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL abort_nodone: got done pulse want none"); end
        read_all(0, "abort");
        pat_a = 16'hA5A5;
    endtask

    task automatic test_abort_done;
        int t0, t;
        bit dr;
        push_frame(16'hA5A5, 0, 31);
        launch(0, 0, t0);
        wait_done(0, 200, t, dr);
        abort_a = 1;
        @(negedge clk);
        abort_a = 0;
        vectors++; if (fc_a !== 16'(exp_fc_a)) begin miscompares++; $display("FAIL abort_done_cnt: got %0d want %0d", fc_a, exp_fc_a); end
        vectors++; if ({busy_a, snap_a} !== 2'b00) begin miscompares++; $display("FAIL abort_done_flags: got %b want 00", {busy_a, snap_a}); end
        read_all(0, "abort_done");
    endtask

    task automatic test_start_held;
        int t0, t;
        bit dr, extra = 0;
        push_frame(16'hA5A5, 0, 31);
        launch(0, 1, t0);
        wait_done(0, 200, t, dr);
        start_a = 0;
        @(negedge clk);
        exp_fc_a++;
        vectors++; if (fc_a !== 16'(exp_fc_a)) begin miscompares++; $display("FAIL held_cnt: got %0d want %0d", fc_a, exp_fc_a); end
        for (int i = 0; i < 100; i++) begin
            if (done_a !== 1'b0 || busy_a !== 1'b0) extra = 1;
            @(negedge clk);
        end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL held_once: got second frame want one"); end
        read_all(0, "held");
    endtask

    task automatic test_async_reset;
        int t0, t;
        bit dr;
        launch(0, 0, t0);
        repeat (20) @(negedge clk);
        rd_idx = 5'd0;
        @(posedge clk);
        #2;
        rstn = 0;
        #1;
        vectors++; if ({busy_a, done_a, snap_a} !== 3'b000) begin miscompares++; $display("FAIL arst_flags: got %b want 000", {busy_a, done_a, snap_a}); end
        vectors++; if (fc_a !== 16'd0 || fc_b !== 2'd0) begin miscompares++; $display("FAIL arst_cnt: got %0d/%0d want 0", fc_a, fc_b); end
        vectors++; if (rd_a !== 32'd0 || rd_b !== 32'd0) begin miscompares++; $display("FAIL arst_buf: got %h/%h want 0", rd_a, rd_b); end
        vectors++; if (addr_a !== live_sel) begin miscompares++; $display("FAIL arst_addr: got %0d want %0d", addr_a, live_sel); end
        exp_fc_a = 0;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        push_frame(16'hA5A5, 0, 31);
        launch(0, 0, t0);
        wait_done(0, 200, t, dr);
        vectors++; if (t - t0 !== 64) begin miscompares++; $display("FAIL arst_latency: got %0d want 64", t - t0); end
        @(negedge clk);
        exp_fc_a++;
        vectors++; if ({snap_a, fc_a} !== {1'b1, 16'(exp_fc_a)}) begin miscompares++; $display("FAIL arst_fresh: got %b/%0d want 1/%0d", snap_a, fc_a, exp_fc_a); end
        read_all(0, "arst");
    endtask

    task automatic test_wrap;
        int t0, t;
        bit dr;
        cont_b = 1;
        launch(1, 0, t0);
        for (int i = 1; i <= 4; i++) begin
            wait_done(1, 300, t, dr);
            if (i == 4) cont_b = 0;
            @(negedge clk);
            vectors++; if (fc_b !== 2'(i)) begin miscompares++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, fc_b, 2'(i)); end
        end
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL wrap_stop: got busy=%b want 0", busy_b); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_settle();
        test_continuous();
        test_abort();
        test_abort_done();
        test_start_held();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/debug_scan_capture.md
Name: debug_scan_capture

Overview:
Requester side of the 5-bit debug-address / 32-bit test-signal sampling interface. It drives `Debug_addr` into the CPU test multiplexer and walks all 32 addresses. At each address it waits a settle interval, then captures `Test_signal` into a 32x32 snapshot buffer. The VGA/UART debug front end reads coherent pipeline snapshots from that buffer through an indexed read port; when the block is idle, `Debug_addr` passes a live selection straight through.

Parameters:
SETTLE_CYCLES, 1, wait cycles between driving an address and sampling `Test_signal` (legal 0..15)
FRAME_CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  request one scan frame; sampled in IDLE only
continuous  in  1  when 1, DONE re-enters scan at address 0 instead of IDLE
abort  in  1  terminate scan, return to IDLE
live_sel  in  5  address driven on `Debug_addr` while IDLE
Debug_addr  out  5  address to the test multiplexer
Test_signal  in  32  sampled data from the test multiplexer
busy  out  1  1 in SAMPLE or DONE
done  out  1  one-cycle pulse, frame complete
snap_valid  out  1  buffer holds one complete, unaborted frame
frame_cnt  out  FRAME_CNT_W  completed-frame count, wraps
rd_idx  in  5  buffer read index
rd_data  out  32  buf[rd_idx], combinational read

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, addr_q=0, wait_cnt=0, done=0, snap_valid=0, frame_cnt=0, all buffer words=0.
  - `Debug_addr`=`live_sel` after reset, since IDLE passes it through.
  - Reset mid-scan discards the frame.
- FSM states: IDLE, SAMPLE, DONE.
- IDLE:
  - `Debug_addr`=`live_sel` (combinational).
  - start=1 -> addr_q=0, wait_cnt=SETTLE_CYCLES, go to SAMPLE, snap_valid cleared.
- SAMPLE:
  - `Debug_addr`=addr_q.
  - wait_cnt!=0 -> wait_cnt--.
  - wait_cnt==0 -> buf[addr_q]<=`Test_signal`.
    - addr_q==31 -> DONE.
    - else addr_q++, wait_cnt=SETTLE_CYCLES.
- DONE (one cycle):
  - done=1, frame_cnt++ (wraps at 2^FRAME_CNT_W), snap_valid<=1.
  - continuous=1 -> SAMPLE with addr_q=0, wait_cnt=SETTLE_CYCLES, snap_valid stays 1.
  - continuous=0 -> IDLE.
  - `Debug_addr`=31 during DONE.
- Timing (start sampled at edge 0):
  - Word k is captured at edge (k+1)*(SETTLE_CYCLES+1).
  - done is high in the cycle after edge 32*(SETTLE_CYCLES+1).
  - SETTLE_CYCLES=1: 64-cycle frame; continuous period 65 cycles.
- done is a registered output: high only while state==DONE.
- start while busy is ignored; start held high in IDLE launches exactly one frame per IDLE entry.
- abort:
  - Has priority over every other transition in SAMPLE and DONE; next state IDLE, snap_valid<=0.
  - frame_cnt is not incremented, even if abort coincides with DONE.
  - Words already captured remain in the buffer.
- Buffer read and write interaction:
  - rd_data reflects buffer contents after the edge; same-cycle write to rd_idx is visible the next cycle, with no bypass.
  - During a continuous scan, reads may mix frames; consumers gate on the done pulse.
- live_sel changes during a scan have no effect on `Debug_addr`.

Test Plan:
- Single frame, SETTLE_CYCLES=1, `Test_signal` model = 32'hA5A50000 | `Debug_addr`:
  - Pulse start -> done high exactly 64 cycles after start edge; frame_cnt=1, snap_valid=1.
  - rd_idx=0..31 returns 32'hA5A50000..32'hA5A5001F.
- Settle check, SETTLE_CYCLES=2, model registers `Debug_addr` with 2-cycle delay:
  - Frame done at cycle 96; buf[7]=32'hA5A50007, no stale values.
- Continuous mode, continuous=1:
  - done pulses at cycles 64, 129, 194; frame_cnt=3; busy never drops.
  - Deassert continuous -> IDLE after next DONE.
- Abort at cycle 30, SETTLE_CYCLES=1 (addr_q=14):
  - Next cycle IDLE, snap_valid=0, frame_cnt unchanged, no done pulse.
  - buf[0..13] valid; `Debug_addr`=`live_sel`=5'd9.
- Async reset asserted mid-frame, between clock edges:
  - All outputs reset immediately; buf[0]=0.
  - start after release yields a full fresh frame.
- Edge cases:
  - start held high during a scan -> exactly one frame.
  - frame_cnt with FRAME_CNT_W=2 wraps 3->0 on fourth frame.
  - abort coincident with DONE -> no count increment.
